// File: rtl/i2s_audio_tx.sv
// Philips-format I2S transmitter: derives SCK/WS from MasterCLK and serialises
// a 32-bit stereo word {Left[15:0], Right[15:0]} MSB first, one-bit WS delay.
// Optional feature macro: I2S_MUTE_EN adds a Mute input that zeroes the latched frame.
module i2s_audio_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        MasterCLK,
    input  logic        Reset,
`ifdef I2S_MUTE_EN
    input  logic        Mute,
`endif
    input  logic [31:0] InputData,
    output logic        SyncCLK,
    output logic        I2S_CLK,
    output logic        I2S_WS,
    output logic        I2S_DATA
);

    localparam int unsigned DIV_W   = 8;
    localparam int unsigned SLOT_W  = 5;
    localparam int unsigned FRAME_W = 32;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_q,   div_d;
    logic               sck_q,   sck_d;
    logic [SLOT_W-1:0]  slot_q,  slot_d;
    logic               ws_q,    ws_d;
    logic               data_q,  data_d;
    logic               sync_q,  sync_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               rbit_q,  rbit_d;

    logic               wrap;
    logic               sck_fall;
    logic [FRAME_W-1:0] frame_in;

    // Frame source: muted frames latch silence instead of the sample
`ifdef I2S_MUTE_EN
    assign frame_in = Mute ? '0 : InputData;
`else
    assign frame_in = InputData;
`endif

    // Divider wrap marks an SCK edge; a wrap while SCK is high is a falling edge
    assign wrap     = (div_q == DIV_LAST);
    assign sck_fall = wrap & sck_q;

    // Next-state logic; slot_q holds the index of the slot the next fall starts
    always_comb begin
        div_d   = wrap ? '0 : div_q + DIV_W'(1);
        sck_d   = wrap ? ~sck_q : sck_q;
        slot_d  = slot_q;
        ws_d    = ws_q;
        data_d  = data_q;
        sync_d  = 1'b0;
        shift_d = shift_q;
        rbit_d  = rbit_q;
        if (sck_fall) begin
            slot_d = slot_q + SLOT_W'(1);
            ws_d   = slot_q[SLOT_W-1];
            if (slot_q == '0) begin
                // Delayed LSB of the previous right word, then load the new frame
                sync_d  = 1'b1;
                data_d  = rbit_q;
                shift_d = frame_in;
                rbit_d  = frame_in[0];
            end else begin
                data_d  = shift_q[FRAME_W-1];
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
        end
    end

    // State registers, all cleared by the asynchronous active-low reset
    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            div_q   <= '0;
            sck_q   <= 1'b0;
            slot_q  <= '0;
            ws_q    <= 1'b0;
            data_q  <= 1'b0;
            sync_q  <= 1'b0;
            shift_q <= '0;
            rbit_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            sck_q   <= sck_d;
            slot_q  <= slot_d;
            ws_q    <= ws_d;
            data_q  <= data_d;
            sync_q  <= sync_d;
            shift_q <= shift_d;
            rbit_q  <= rbit_d;
        end
    end

    assign I2S_CLK  = sck_q;
    assign I2S_WS   = ws_q;
    assign I2S_DATA = data_q;
    assign SyncCLK  = sync_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx with CLK_DIV=2: table of frames with hand-computed
// slot sequences, plus reset corner cases (long reset, async reset mid slot 20).
module tb_i2s_audio_tx;

    localparam int unsigned D         = 2;
    localparam int unsigned FRAME_CYC = 64 * D;
`ifdef I2S_MUTE_EN
    localparam int unsigned N = 7;
`else
    localparam int unsigned N = 6;
`endif

    // exp: bit 31 = slot 0, bit 30 = slot 1, ..., bit 0 = slot 31
    typedef struct {
        logic [31:0] data;
        logic        mute;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [N];

    logic        MasterCLK;
    logic        Reset;
    logic [31:0] InputData;
    logic        SyncCLK;
    logic        I2S_CLK;
    logic        I2S_WS;
    logic        I2S_DATA;
`ifdef I2S_MUTE_EN
    logic        Mute;
`endif

    int checks;
    int errors;

    i2s_audio_tx #(.CLK_DIV(D)) dut (
        .MasterCLK (MasterCLK),
        .Reset     (Reset),
`ifdef I2S_MUTE_EN
        .Mute      (Mute),
`endif
        .InputData (InputData),
        .SyncCLK   (SyncCLK),
        .I2S_CLK   (I2S_CLK),
        .I2S_WS    (I2S_WS),
        .I2S_DATA  (I2S_DATA)
    );

    initial MasterCLK = 1'b0;
    always #5 MasterCLK = ~MasterCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge MasterCLK);
        #1;
    endtask

    // Release reset and run N frames, checking every cycle against the timing model
    task automatic run_sequence(input string tag);
        int          bad  [N];
        logic [31:0] word [N];
        logic        prev_sck;
        logic        esck, ews, edata, esync;
        int          fc, fr, slot;
        for (int f = 0; f < int'(N); f++) begin
            bad[f]  = 0;
            word[f] = '0;
        end
        InputData = tbl[0].data;
`ifdef I2S_MUTE_EN
        Mute = tbl[0].mute;
`endif
        @(negedge MasterCLK);
        Reset    = 1'b1;
        prev_sck = 1'b0;
        for (int c = 1; c < int'(2 * D + N * FRAME_CYC); c++) begin
            step();
            esck = 1'(((c / int'(D)) % 2));
            if (c < int'(2 * D)) begin
                fr = 0; slot = 0;
                ews = 1'b0; edata = 1'b0; esync = 1'b0;
            end else begin
                fc    = c - int'(2 * D);
                fr    = fc / int'(FRAME_CYC);
                slot  = (fc / int'(2 * D)) % 32;
                ews   = (slot >= 16);
                edata = tbl[fr].exp[31 - slot];
                esync = ((fc % int'(FRAME_CYC)) == 0);
                if (I2S_CLK && !prev_sck)
                    word[fr][31 - slot] = I2S_DATA;
                if ((fc % int'(FRAME_CYC)) == int'(16 * D + D) && (fr + 1) < int'(N)) begin
                    InputData = tbl[fr + 1].data;
`ifdef I2S_MUTE_EN
                    Mute = tbl[fr + 1].mute;
`endif
                end
            end
            if (c == int'(2 * D))
                check($sformatf("%s_sync_first", tag), 32'(SyncCLK), 32'd1);
            if ({I2S_CLK, I2S_WS, I2S_DATA, SyncCLK} !== {esck, ews, edata, esync})
                bad[fr]++;
            prev_sck = I2S_CLK;
        end
        for (int f = 0; f < int'(N); f++) begin
            check($sformatf("%s_frame%0d_bad_cycles", tag, f), 32'(bad[f]), 32'd0);
            check($sformatf("%s_frame%0d_bits", tag, f), word[f], tbl[f].exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0] = '{data: 32'hA5F0_0F5A, mute: 1'b0, exp: 32'h52F8_07AD};
        tbl[1] = '{data: 32'h1234_5678, mute: 1'b0, exp: 32'h091A_2B3C};
        tbl[2] = '{data: 32'hFFFF_FFFF, mute: 1'b0, exp: 32'h7FFF_FFFF};
        tbl[3] = '{data: 32'h0000_0000, mute: 1'b0, exp: 32'h8000_0000};
        tbl[4] = '{data: 32'hFFFF_FFFF, mute: 1'b0, exp: 32'h7FFF_FFFF};
        tbl[5] = '{data: 32'h0000_0000, mute: 1'b0, exp: 32'h8000_0000};
`ifdef I2S_MUTE_EN
        tbl[6] = '{data: 32'hFFFF_FFFF, mute: 1'b1, exp: 32'h0000_0000};
        Mute = 1'b0;
`endif

        Reset     = 1'b0;
        InputData = 32'h0;
        repeat (10) step();
        check("rst_sck",  32'(I2S_CLK),  32'd0);
        check("rst_ws",   32'(I2S_WS),   32'd0);
        check("rst_data", 32'(I2S_DATA), 32'd0);
        check("rst_sync", 32'(SyncCLK),  32'd0);

        run_sequence("run1");

        // Next frame latches all ones; cut it mid slot 20 with an async reset
        InputData = 32'hFFFF_FFFF;
`ifdef I2S_MUTE_EN
        Mute = 1'b0;
`endif
        repeat (20 * 2 * D + 2) step();
        check("pre_rst_ws_data", 32'({I2S_WS, I2S_DATA}), 32'd3);
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst_sck",  32'(I2S_CLK),  32'd0);
        check("async_rst_ws",   32'(I2S_WS),   32'd0);
        check("async_rst_data", 32'(I2S_DATA), 32'd0);
        check("async_rst_sync", 32'(SyncCLK),  32'd0);
        repeat (3) step();

        run_sequence("run2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
